// File: rtl/wb_port_arbiter.sv
// Purpose: shares the register-file write port between single-cycle source A and buffered multi-cycle source B.
// Latency: selection to WE/WriteReg/WriteData is 1 cycle; B accept to WE is at least 2 cycles.
// Backpressure: B_Ready drops while the B buffer is full; A_Stall holds A only when a starved B head is forced.
module wb_port_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        A_Valid,
  input  logic [4:0]  A_Reg,
  input  logic [31:0] A_Data,
  output logic        A_Stall,
  input  logic        B_Valid,
  output logic        B_Ready,
  input  logic [4:0]  B_Reg,
  input  logic [31:0] B_Data,
  input  logic        Issue_Valid,
  input  logic [4:0]  Issue_Reg,
  output logic [31:0] Busy,
  output logic        WE,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {SEL_IDLE, SEL_A, SEL_B} sel_e;

  // B result buffer; entries are only meaningful below count_q, so storage needs no reset
  logic [4:0]    fifo_reg_q [FIFO_DEPTH];
  logic [31:0]   fifo_dat_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   busy_q, busy_d;
  logic          we_q, we_d;
  logic [4:0]    wreg_q, wreg_d;
  logic [31:0]   wdata_q, wdata_d;

  logic fifo_empty, fifo_full, a_req, force_b, push, pop;
  sel_e sel;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign a_req      = A_Valid && (A_Reg != 5'd0);
  // Full is judged on the pre-pop count, so a same-cycle pop never frees a slot early
  assign B_Ready    = !fifo_full;
  // A destination of r0 is never buffered; the handshake still completes
  assign push       = B_Valid && B_Ready && (B_Reg != 5'd0);
  assign force_b    = !fifo_empty && (starve_q >= SW'(STARVE_LIMIT));
  assign A_Stall    = force_b && a_req;
  assign pop        = (sel == SEL_B);

  assign Busy      = busy_q;
  assign WE        = we_q;
  assign WriteReg  = wreg_q;
  assign WriteData = wdata_q;

  // Pick the write-port winner and compute every next-state value
  always_comb begin
    sel      = SEL_IDLE;
    we_d     = 1'b0;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    starve_d = starve_q;
    busy_d   = busy_q;

    if (force_b) begin
      sel = SEL_B;
    end else if (a_req) begin
      sel = SEL_A;
    end else if (!fifo_empty) begin
      sel = SEL_B;
    end

    if (sel == SEL_B) begin
      we_d    = 1'b1;
      wreg_d  = fifo_reg_q[rd_ptr_q];
      wdata_d = fifo_dat_q[rd_ptr_q];
    end else if (sel == SEL_A) begin
      we_d    = 1'b1;
      wreg_d  = A_Reg;
      wdata_d = A_Data;
    end

    // Count only losses of a waiting head to A; any pop or an empty buffer restarts it
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (sel == SEL_A && starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end

    // Clear first so a same-cycle reissue to the same register keeps it busy
    if (pop) begin
      busy_d[fifo_reg_q[rd_ptr_q]] = 1'b0;
    end
    if (Issue_Valid && Issue_Reg != 5'd0) begin
      busy_d[Issue_Reg] = 1'b1;
    end

    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Control state and registered write-port outputs, with synchronous reset
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      busy_q   <= '0;
      we_q     <= 1'b0;
      wreg_q   <= 5'd0;
      wdata_q  <= 32'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_d;
      starve_q <= starve_d;
      busy_q   <= busy_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  // Buffer storage write on accepted, non-r0 B results
  always_ff @(posedge CLK) begin
    if (Reset && push) begin
      fifo_reg_q[wr_ptr_q] <= B_Reg;
      fifo_dat_q[wr_ptr_q] <= B_Data;
    end
  end

endmodule
